// File: rtl/contador_ud_m.sv
// Up/down modulo counter with a live programmable modulus, synchronous load,
// optional saturation, decoded end/start/middle flags and a one-cycle wrap pulse.
module contador_ud_m #(
  parameter int N      = 13,
  parameter bit SATURA = 1'b0
) (
  input  logic         clock,
  input  logic         zera_as_n,
  input  logic         zera_s,
  input  logic         conta,
  input  logic         sobe,
  input  logic         carrega,
  input  logic [N-1:0] D,
  input  logic [N-1:0] modulo,
  output logic [N-1:0] Q,
  output logic         fim,
  output logic         inicio,
  output logic         meio,
  output logic         estouro
);

  logic [N-1:0] q_q, q_d;
  logic         estouro_q, estouro_d;
  logic [N-1:0] top;
  logic [N-1:0] mid;

  // modulo=0 stands for 2^N, so modulo-1 in N-bit arithmetic already yields 2^N-1.
  assign top = modulo - N'(1);
  assign mid = (modulo == '0) ? {1'b0, {(N-1){1'b1}}} : ((modulo >> 1) - N'(1));

  always_comb begin
    q_d       = q_q;
    estouro_d = 1'b0;
    if (zera_s) begin
      q_d = '0;
    end else if (carrega) begin
      q_d = (D > top) ? top : D;
    end else if (conta) begin
      if (sobe) begin
        if (q_q < top) begin
          q_d = q_q + N'(1);
        end else begin
          q_d       = SATURA ? top : '0;
          estouro_d = 1'b1;
        end
      end else begin
        // A live reduction of modulo can leave Q above TOP; the step pulls it back.
        if (q_q > top) begin
          q_d       = top;
          estouro_d = 1'b1;
        end else if (q_q != '0) begin
          q_d = q_q - N'(1);
        end else begin
          q_d       = SATURA ? '0 : top;
          estouro_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge zera_as_n) begin
    if (!zera_as_n) begin
      q_q       <= '0;
      estouro_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      estouro_q <= estouro_d;
    end
  end

  assign Q       = q_q;
  assign estouro = estouro_q;
  assign fim     = (q_q == top);
  assign inicio  = (q_q == '0);
  assign meio    = (modulo != N'(1)) && (q_q == mid);

endmodule

// File: tb/tb_contador_ud_m.sv
// Bench for contador_ud_m: wrapping and saturating instances (N=4) driven in
// parallel and compared against an integer model of the counting rules.
module tb_contador_ud_m;

  localparam int N = 4;

  logic         clock;
  logic         zera_as_n;
  logic         zera_s;
  logic         conta;
  logic         sobe;
  logic         carrega;
  logic [N-1:0] D;
  logic [N-1:0] modulo;

  logic [N-1:0] q0, q1;
  logic         fim0, fim1, ini0, ini1, meio0, meio1, est0, est1;
  logic [7:0]   obs [2];

  int nvec = 0;
  int nerr = 0;
  int m_q  [2];
  bit m_est[2];

  contador_ud_m #(.N(N), .SATURA(1'b0)) u_wrap (
    .clock(clock), .zera_as_n(zera_as_n), .zera_s(zera_s), .conta(conta),
    .sobe(sobe), .carrega(carrega), .D(D), .modulo(modulo),
    .Q(q0), .fim(fim0), .inicio(ini0), .meio(meio0), .estouro(est0)
  );

  contador_ud_m #(.N(N), .SATURA(1'b1)) u_sat (
    .clock(clock), .zera_as_n(zera_as_n), .zera_s(zera_s), .conta(conta),
    .sobe(sobe), .carrega(carrega), .D(D), .modulo(modulo),
    .Q(q1), .fim(fim1), .inicio(ini1), .meio(meio1), .estouro(est1)
  );

  assign obs[0] = {q0, est0, fim0, ini0, meio0};
  assign obs[1] = {q1, est1, fim1, ini1, meio1};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int topv(int m);
    return (m == 0) ? (1 << N) - 1 : m - 1;
  endfunction

  function automatic int midv(int m);
    if (m == 0) return (1 << (N - 1)) - 1;
    if (m >= 2) return m / 2 - 1;
    return -1;
  endfunction

  function automatic logic [7:0] exp_vec(int k);
    int t, q;
    t = topv(int'(modulo));
    q = m_q[k];
    return {4'(q), m_est[k], q == t, q == 0, q == midv(int'(modulo))};
  endfunction

  // Counting rules in plain integers; instance 1 saturates, instance 0 wraps.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int t, q;
      bit e, sat;
      sat = (k == 1);
      t = topv(int'(modulo));
      q = m_q[k];
      e = 1'b0;
      if (zera_s) q = 0;
      else if (carrega) q = (int'(D) > t) ? t : int'(D);
      else if (conta && sobe) begin
        if (q < t) q = q + 1;
        else begin q = sat ? t : 0; e = 1'b1; end
      end else if (conta) begin
        if (q > t) begin q = t; e = 1'b1; end
        else if (q > 0) q = q - 1;
        else begin q = sat ? 0 : t; e = 1'b1; end
      end
      m_q[k]   = q;
      m_est[k] = e;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic set_in(bit zs, bit ld, bit en, bit up, int d, int m);
    zera_s  = zs;
    carrega = ld;
    conta   = en;
    sobe    = up;
    D       = 4'(d);
    modulo  = 4'(m);
  endtask

  task automatic test_reset();
    zera_as_n = 1'b0;
    set_in(0, 0, 1, 1, 0, 10);
    m_q   = '{0, 0};
    m_est = '{0, 0};
    #12;
    for (int k = 0; k < 2; k++) begin
      nvec++;
      if (obs[k] !== exp_vec(k)) begin
        nerr++;
        $display("FAIL reset inst=%0d got=%h want=%h", k, obs[k], exp_vec(k));
      end
    end
    #5 zera_as_n = 1'b1;
  endtask

  task automatic test_count_up();
    int pulses = 0;
    set_in(1, 0, 0, 1, 0, 10);
    tick();
    set_in(0, 0, 1, 1, 0, 10);
    for (int c = 0; c < 12; c++) begin
      tick();
      if (est0) pulses++;
      for (int k = 0; k < 2; k++) begin
        nvec++;
        if (obs[k] !== exp_vec(k)) begin
          nerr++;
          $display("FAIL count_up inst=%0d cyc=%0d got=%h want=%h", k, c, obs[k], exp_vec(k));
        end
      end
    end
    nvec++;
    if (pulses != 1 || q0 !== 4'd2) begin
      nerr++;
      $display("FAIL count_up_pulses got=%0d q=%0d want=1 q=2", pulses, q0);
    end
  endtask

  task automatic test_count_down();
    set_in(1, 0, 0, 0, 0, 10);
    tick();
    set_in(0, 0, 1, 0, 0, 10);
    for (int c = 0; c < 12; c++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        nvec++;
        if (obs[k] !== exp_vec(k)) begin
          nerr++;
          $display("FAIL count_down inst=%0d cyc=%0d got=%h want=%h", k, c, obs[k], exp_vec(k));
        end
      end
    end
  endtask

  task automatic test_saturate();
    set_in(0, 1, 0, 1, 8, 10);
    tick();
    set_in(0, 0, 1, 1, 0, 10);
    for (int c = 0; c < 4; c++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        nvec++;
        if (obs[k] !== exp_vec(k)) begin
          nerr++;
          $display("FAIL sat_up inst=%0d cyc=%0d got=%h want=%h", k, c, obs[k], exp_vec(k));
        end
      end
    end
    nvec++;
    if (q1 !== 4'd9 || est1 !== 1'b1) begin
      nerr++;
      $display("FAIL sat_hold got q=%0d e=%0b want q=9 e=1", q1, est1);
    end
    set_in(1, 0, 0, 0, 0, 10);
    tick();
    set_in(0, 0, 1, 0, 0, 10);
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        nvec++;
        if (obs[k] !== exp_vec(k)) begin
          nerr++;
          $display("FAIL sat_down inst=%0d cyc=%0d got=%h want=%h", k, c, obs[k], exp_vec(k));
        end
      end
    end
  endtask

  task automatic test_load_priority();
    int dv [4] = '{7, 12, 5, 3};
    bit zs [4] = '{0, 0, 1, 0};
    bit en [4] = '{0, 0, 0, 1};
    int wq [4] = '{7, 9, 0, 3};
    for (int c = 0; c < 4; c++) begin
      set_in(zs[c], 1, en[c], 1, dv[c], 10);
      tick();
      for (int k = 0; k < 2; k++) begin
        nvec++;
        if (obs[k] !== exp_vec(k)) begin
          nerr++;
          $display("FAIL load inst=%0d case=%0d got=%h want=%h", k, c, obs[k], exp_vec(k));
        end
      end
      nvec++;
      if (int'(q0) != wq[c]) begin
        nerr++;
        $display("FAIL load_value case=%0d got=%0d want=%0d", c, q0, wq[c]);
      end
    end
  endtask

  task automatic test_modulo_live();
    set_in(0, 1, 0, 1, 8, 10);
    tick();
    set_in(0, 0, 1, 1, 0, 5);
    #1;
    for (int k = 0; k < 2; k++) begin
      nvec++;
      if (obs[k] !== exp_vec(k)) begin
        nerr++;
        $display("FAIL mod_shrink_flags inst=%0d got=%h want=%h", k, obs[k], exp_vec(k));
      end
    end
    tick();
    nvec++;
    if (q0 !== 4'd0 || est0 !== 1'b1 || q1 !== 4'd4 || est1 !== 1'b1) begin
      nerr++;
      $display("FAIL mod_shrink got q0=%0d e0=%0b q1=%0d e1=%0b want 0 1 4 1", q0, est0, q1, est1);
    end
    set_in(1, 0, 0, 1, 0, 0);
    tick();
    set_in(0, 0, 1, 1, 0, 0);
    for (int c = 0; c < 18; c++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        nvec++;
        if (obs[k] !== exp_vec(k)) begin
          nerr++;
          $display("FAIL mod_zero inst=%0d cyc=%0d got=%h want=%h", k, c, obs[k], exp_vec(k));
        end
      end
    end
    set_in(0, 0, 1, 1, 0, 1);
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        nvec++;
        if (obs[k] !== exp_vec(k)) begin
          nerr++;
          $display("FAIL mod_one inst=%0d cyc=%0d got=%h want=%h", k, c, obs[k], exp_vec(k));
        end
      end
    end
  endtask

  task automatic test_async_reset();
    set_in(1, 0, 0, 1, 0, 10);
    tick();
    set_in(0, 0, 1, 1, 0, 10);
    repeat (6) tick();
    nvec++;
    if (q0 !== 4'd6) begin
      nerr++;
      $display("FAIL async_setup got=%0d want=6", q0);
    end
    #3 zera_as_n = 1'b0;
    m_q   = '{0, 0};
    m_est = '{0, 0};
    #1;
    for (int k = 0; k < 2; k++) begin
      nvec++;
      if (obs[k] !== exp_vec(k)) begin
        nerr++;
        $display("FAIL async_clear inst=%0d got=%h want=%h", k, obs[k], exp_vec(k));
      end
    end
    #2 zera_as_n = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      nvec++;
      if (obs[k] !== exp_vec(k)) begin
        nerr++;
        $display("FAIL async_resume inst=%0d got=%h want=%h", k, obs[k], exp_vec(k));
      end
    end
  endtask

  task automatic test_random();
    int m = 10;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(15) == 0) m = $urandom_range(15);
      set_in($urandom_range(19) == 0, $urandom_range(7) == 0, $urandom_range(3) != 0,
             $urandom_range(1) == 1, $urandom_range(15), m);
      tick();
      for (int k = 0; k < 2; k++) begin
        nvec++;
        if (obs[k] !== exp_vec(k)) begin
          nerr++;
          $display("FAIL random inst=%0d cyc=%0d mod=%0d got=%h want=%h", k, c, m, obs[k], exp_vec(k));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_saturate();
    test_load_priority();
    test_modulo_live();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
